icache_axi_rd_bridge: RTL and testbench

Read-side responder for the instruction cache's miss interface (rd_req/rd_type/rd_addr/rd_rdy/ret_valid/ret_data). It converts one accepted cache read request into one AXI3/AXI4 read transaction and assembles the R beats into a 128-bit return word. It sits between the icache and the AXI crossbar/arbiter, with one outstanding transaction at a time.

---
 rtl/icache_axi_rd_bridge.sv | 147 ++++++++++++++
 tb/tb_icache_axi_rd_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_axi_rd_bridge.sv
// Instruction-cache miss port to AXI read bridge: one outstanding read at a time,
// R beats are packed into a 128-bit return word handed back with a one-cycle pulse.
module icache_axi_rd_bridge #(
   parameter logic [3:0] ARID    = 4'd0,
   parameter logic [3:0] ARCACHE = 4'b0000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         rd_req,
   input  logic [2:0]   rd_type,
   input  logic [31:0]  rd_addr,
   output logic         rd_rdy,
   output logic         ret_valid,
   output logic [127:0] ret_data,
   output logic         ret_err,
   output logic [3:0]   arid,
   output logic [31:0]  araddr,
   output logic [7:0]   arlen,
   output logic [2:0]   arsize,
   output logic [1:0]   arburst,
   output logic [1:0]   arlock,
   output logic [3:0]   arcache,
   output logic [2:0]   arprot,
   output logic         arvalid,
   input  logic         arready,
   input  logic [3:0]   rid,
   input  logic [31:0]  rdata,
   input  logic [1:0]   rresp,
   input  logic         rlast,
   input  logic         rvalid,
   output logic         rready
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;

   logic [1:0]  state_q,  state_d;
   logic [31:0] araddr_q, araddr_d;
   logic [7:0]  arlen_q,  arlen_d;
   logic [2:0]  arsize_q, arsize_d;
   logic [1:0]  cnt_q,    cnt_d;
   logic        w3_q,     w3_d;
   logic        err_q,    err_d;
   logic        accept;
   logic        beat;
   logic        rid_unused;

   assign accept     = (state_q == ST_IDLE) && rd_req;
   assign beat       = (state_q == ST_DATA) && rvalid;
   assign rid_unused = ^rid;

   always_comb begin
      state_d  = state_q;
      araddr_d = araddr_q;
      arlen_d  = arlen_q;
      arsize_d = arsize_q;
      cnt_d    = cnt_q;
      w3_d     = w3_q;
      err_d    = err_q;
      case (state_q)
         ST_IDLE: begin
            if (rd_req) begin
               araddr_d = rd_addr;
               arlen_d  = (rd_type == 3'b100) ? 8'd3 : 8'd0;
               case (rd_type)
                  3'b000:  arsize_d = 3'd0;
                  3'b001:  arsize_d = 3'd1;
                  default: arsize_d = 3'd2;
               endcase
               cnt_d   = 2'd0;
               w3_d    = 1'b0;
               err_d   = 1'b0;
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (arready) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (rvalid) begin
               // A second write to word 3 means the slave sent more beats than we can hold.
               if ((rresp != 2'b00) || ((cnt_q == 2'd3) && w3_q)) err_d = 1'b1;
               if (cnt_q == 2'd3) w3_d = 1'b1;
               else               cnt_d = cnt_q + 2'd1;
               if (rlast) state_d = ST_RESP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         araddr_q <= '0;
         arlen_q  <= '0;
         arsize_q <= '0;
         cnt_q    <= '0;
         w3_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         araddr_q <= araddr_d;
         arlen_q  <= arlen_d;
         arsize_q <= arsize_d;
         cnt_q    <= cnt_d;
         w3_q     <= w3_d;
         err_q    <= err_d;
      end
   end

   // Return buffer: each word is cleared on accept and written by the beat aimed at it.
   for (genvar gi = 0; gi < 4; gi++) begin : g_word
      logic [31:0] word_q, word_d;

      always_comb begin
         word_d = word_q;
         if (accept)                           word_d = '0;
         else if (beat && (cnt_q == 2'(gi)))   word_d = rdata;
      end

      always_ff @(posedge clk) begin
         if (reset) word_q <= '0;
         else       word_q <= word_d;
      end

      assign ret_data[32*gi +: 32] = word_q;
   end

   assign rd_rdy    = (state_q == ST_IDLE);
   assign arvalid   = (state_q == ST_ADDR);
   assign rready    = (state_q == ST_DATA);
   assign ret_valid = (state_q == ST_RESP);
   assign ret_err   = (state_q == ST_RESP) && err_q;

   assign arid    = ARID;
   assign araddr  = araddr_q;
   assign arlen   = arlen_q;
   assign arsize  = arsize_q;
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = ARCACHE;
   assign arprot  = 3'b000;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Scoreboard bench for icache_axi_rd_bridge: directed cases followed by random
// reads, checked against a beat-list reference model.
module tb_icache_axi_rd_bridge;

   logic         clk = 1'b0;
   logic         reset;
   logic         rd_req;
   logic [2:0]   rd_type;
   logic [31:0]  rd_addr;
   logic         rd_rdy;
   logic         ret_valid;
   logic [127:0] ret_data;
   logic         ret_err;
   logic [3:0]   arid;
   logic [31:0]  araddr;
   logic [7:0]   arlen;
   logic [2:0]   arsize;
   logic [1:0]   arburst;
   logic [1:0]   arlock;
   logic [3:0]   arcache;
   logic [2:0]   arprot;
   logic         arvalid;
   logic         arready;
   logic [3:0]   rid;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rlast;
   logic         rvalid;
   logic         rready;

   always #5 clk = ~clk;

   icache_axi_rd_bridge dut (
      .clk(clk), .reset(reset),
      .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
      .ret_valid(ret_valid), .ret_data(ret_data), .ret_err(ret_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
      .rready(rready)
   );

   typedef struct packed {
      logic [127:0] data;
      logic         err;
   } ret_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
   } ar_t;

   ret_t ret_q[$];
   ar_t  ar_q[$];

   int errors = 0;
   int checks = 0;
   int ar_hs_cnt = 0;
   logic prev_rv = 1'b0;

   logic [31:0]  bdata [8];
   logic [1:0]   bresp [8];
   logic [127:0] last_data;
   bit           have_last = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Return monitor: pops the scoreboard on every ret_valid pulse.
   always @(negedge clk) begin
      if (!reset) begin
         if (ret_valid) begin
            ret_t e;
            chk("ret_single_pulse", 128'(prev_rv), 128'(0));
            if (ret_q.size() == 0) begin
               chk("ret_unexpected", 128'(1), 128'(0));
            end else begin
               e = ret_q.pop_front();
               chk("ret_data", ret_data, e.data);
               chk("ret_err", 128'(ret_err), 128'(e.err));
               $display("ret data=%h err=%0d (exp %h err=%0d)", ret_data, ret_err, e.data, e.err);
            end
         end
         prev_rv = ret_valid;
      end
   end

   // AR monitor: fields must match the pending request on every valid cycle.
   always @(negedge clk) begin
      if (!reset && arvalid) begin
         if (ar_q.size() == 0) begin
            chk("ar_unexpected", 128'(1), 128'(0));
         end else begin
            chk("araddr", 128'(araddr), 128'(ar_q[0].addr));
            chk("arlen", 128'(arlen), 128'(ar_q[0].len));
            chk("arsize", 128'(arsize), 128'(ar_q[0].size));
            chk("ar_const", 128'({arid, arburst, arlock, arcache, arprot}),
                128'({4'd0, 2'b01, 2'b00, 4'b0000, 3'b000}));
            if (arready) begin
               ar_hs_cnt++;
               $display("ar addr=%h len=%0d size=%0d", araddr, arlen, arsize);
               void'(ar_q.pop_front());
            end
         end
      end
   end

   // While the bridge is busy it must not offer to accept.
   always @(negedge clk) begin
      if (!reset && (arvalid || rready || ret_valid))
         chk("rd_rdy_busy", 128'(rd_rdy), 128'(0));
   end

   task automatic check_reset_state(input string tag);
      chk({tag, "_rd_rdy"},   128'(rd_rdy), 128'(1));
      chk({tag, "_ret_valid"}, 128'(ret_valid), 128'(0));
      chk({tag, "_ret_err"},  128'(ret_err), 128'(0));
      chk({tag, "_ret_data"}, ret_data, 128'(0));
      chk({tag, "_arvalid"},  128'(arvalid), 128'(0));
      chk({tag, "_rready"},   128'(rready), 128'(0));
      chk({tag, "_ar_fields"}, 128'({araddr, arlen, arsize}), 128'(0));
   endtask

   // Caller is positioned 1 time unit after a rising edge.
   task automatic run_txn(input logic [2:0] typ, input logic [31:0] addr, input int nb,
                          input int ar_stall, input int r_stall, input bit keep,
                          input int abort_after);
      logic [31:0] w [4];
      logic        err;
      ret_t        e;
      ar_t         a;
      int          hs0;
      int          n;
      bit          ok;

      for (int i = 0; i < 4; i++) w[i] = '0;
      err = 1'b0;
      for (int i = 0; i < nb; i++) begin
         w[(i < 3) ? i : 3] = bdata[i];
         if (bresp[i] != 2'b00 || i >= 4) err = 1'b1;
      end
      e.data = {w[3], w[2], w[1], w[0]};
      e.err  = err;
      a.addr = addr;
      a.len  = (typ == 3'b100) ? 8'd3 : 8'd0;
      a.size = (typ == 3'b000) ? 3'd0 : (typ == 3'b001) ? 3'd1 : 3'd2;
      if (abort_after == 0) ret_q.push_back(e);
      ar_q.push_back(a);
      $display("req type=%b addr=%h beats=%0d", typ, addr, nb);

      rd_req = 1'b1; rd_type = typ; rd_addr = addr;
      hs0 = ar_hs_cnt;

      @(negedge clk);
      chk("accept_ready", 128'(rd_rdy), 128'(1));
      if (have_last) chk("ret_hold", ret_data, last_data);
      n = 0;
      while (!rd_rdy && n < 50) begin @(negedge clk); n++; end
      @(posedge clk); #1;

      for (int s = 0; s < ar_stall; s++) begin @(posedge clk); #1; end
      arready = 1'b1;
      ok = 0;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clk);
         if (arvalid) ok = 1;
         else begin @(posedge clk); #1; end
      end
      if (!ok) chk("ar_timeout", 128'(0), 128'(1));
      @(posedge clk); #1;
      arready = 1'b0;

      for (int i = 0; i < nb; i++) begin
         int st;
         st = (r_stall < 0) ? int'($urandom_range(0, 2)) : r_stall;
         for (int s = 0; s < st; s++) begin @(posedge clk); #1; end
         rvalid = 1'b1; rdata = bdata[i]; rresp = bresp[i]; rlast = (i == nb - 1);
         rid = 4'($urandom);
         ok = 0;
         for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            if (rready) ok = 1;
            else begin @(posedge clk); #1; end
         end
         if (!ok) chk("r_timeout", 128'(0), 128'(1));
         @(posedge clk); #1;
         rvalid = 1'b0; rlast = 1'b0;
         if (abort_after == i + 1) begin
            rd_req = 1'b0;
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
            @(negedge clk);
            check_reset_state("mid_reset");
            have_last = 0;
            @(posedge clk); #1;
            return;
         end
      end

      @(negedge clk);
      chk("ret_on_time", 128'(ret_valid), 128'(1));
      n = 0;
      while (!ret_valid && n < 50) begin @(negedge clk); n++; end
      chk("ar_hs_once", 128'(ar_hs_cnt - hs0), 128'(1));
      last_data = e.data;
      have_last = 1;
      @(posedge clk); #1;
      if (!keep) rd_req = 1'b0;
   endtask

   task automatic set_beats(input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3,
                            input logic [31:0] d4);
      bdata[0] = d0; bdata[1] = d1; bdata[2] = d2; bdata[3] = d3; bdata[4] = d4;
      for (int i = 0; i < 8; i++) bresp[i] = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; rd_req = 1'b0; rd_type = '0; rd_addr = '0;
      arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
      for (int i = 0; i < 8; i++) begin bdata[i] = '0; bresp[i] = '0; end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_state("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // Line read, no stalls
      set_beats(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h0);
      run_txn(3'b100, 32'h1FC0_0100, 4, 0, 0, 0, 0);
      @(posedge clk); #1;

      // Uncached word with AR and R stalls
      set_beats(32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0);
      run_txn(3'b010, 32'hBFC0_0004, 1, 3, 2, 0, 0);

      // Error response on beat 2
      set_beats(32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3, 32'h0);
      bresp[2] = 2'b10;
      run_txn(3'b100, 32'h0000_2040, 4, 0, 0, 0, 0);

      // Persistent rd_req: back-to-back accept the cycle after ret_valid
      set_beats(32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'h0);
      run_txn(3'b100, 32'h0000_3000, 4, 0, 0, 1, 0);
      set_beats(32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0);
      run_txn(3'b000, 32'h0000_3003, 1, 1, 0, 0, 0);

      // Reset after the second beat
      set_beats(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 32'h0);
      run_txn(3'b100, 32'h0000_4000, 4, 0, 0, 0, 2);

      // Overrun: five beats
      set_beats(32'h10000001, 32'h20000002, 32'h30000003, 32'h40000004, 32'h50000005);
      run_txn(3'b100, 32'h0000_5000, 5, 0, 0, 0, 0);

      // Early rlast on beat 2
      set_beats(32'hCAFEF00D, 32'hFACEB00C, 32'h0, 32'h0, 32'h0);
      run_txn(3'b100, 32'h0000_6000, 2, 0, 1, 0, 0);

      // Half-word read
      set_beats(32'h0000BEEF, 32'h0, 32'h0, 32'h0, 32'h0);
      run_txn(3'b001, 32'h0000_7002, 1, 0, 0, 0, 0);

      // Randomized reads
      for (int t = 0; t < 60; t++) begin
         logic [2:0]  typ;
         logic [31:0] addr;
         int          nb;
         int          pick;
         bit          keep;
         pick = int'($urandom_range(0, 9));
         case (pick)
            0, 1, 2, 3: typ = 3'b100;
            4:          typ = 3'b000;
            5:          typ = 3'b001;
            7:          typ = 3'b011;
            8:          typ = 3'b110;
            default:    typ = 3'b010;
         endcase
         addr = $urandom;
         if (typ == 3'b100) begin
            addr[3:0] = 4'h0;
            pick = int'($urandom_range(0, 9));
            nb = (pick < 6) ? 4 : (pick == 6) ? 1 : (pick == 7) ? 2 : (pick == 8) ? 3 : 5;
         end else begin
            nb = 1;
         end
         for (int i = 0; i < 8; i++) begin
            bdata[i] = $urandom;
            bresp[i] = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         end
         keep = (t != 59) && ($urandom_range(0, 3) == 0);
         run_txn(typ, addr, nb, int'($urandom_range(0, 3)), -1, keep, 0);
         if (!keep) begin
            pick = int'($urandom_range(0, 2));
            for (int s = 0; s < pick; s++) begin @(posedge clk); #1; end
         end
      end

      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("ret_queue_drained", 128'(ret_q.size()), 128'(0));
      chk("ar_queue_drained", 128'(ar_q.size()), 128'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
